output_mems: RTL and testbench
==============================

Name: output_mems

Overview:
- Result-side counterpart of the matrix input loader.
- Buffers the M×N result matrix C, which the compute core writes by address. Then acts as an AXI-Stream master and transmits C in row-major address order, asserting TLAST on the final element.
- Tells the compute core when it may write the next result set, and pulses a completion flag when the stream has drained.

Parameters:
- OUTW, 32, width of one C element, signed two's complement.
- M, 7, number of rows of C.
- N, 9, number of columns of C.
- C_ADDR_BITS, $clog2(M*N), localparam, C address width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- C_wr_data  input  OUTW  result element from compute.
- C_wr_addr  input  C_ADDR_BITS  element index, row*N+col.
- C_wr_en  input  1  write strobe.
- results_done  input  1  one-cycle pulse; all M*N elements have been written.
- buf_free  output  1  high while the compute core may write C.
- AXIS_TDATA  output  OUTW  stream data.
- AXIS_TVALID  output  1  stream data valid.
- AXIS_TREADY  input  1  downstream ready.
- AXIS_TLAST  output  1  high on the beat carrying element M*N-1.
- stream_done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Storage: single-port-read synchronous RAM, M*N deep (power-of-2 rounding allowed), OUTW wide. Read data is valid one cycle after the address is presented. No clearing on reset.
- Reset (reset==0 at a clock edge), effective next cycle:
  - state=FILL; read counter=0.
  - AXIS_TVALID=0, AXIS_TLAST=0, AXIS_TDATA=0.
  - buf_free=1, stream_done=0.
  - Applies mid-stream too: the frame is abandoned and no TLAST is emitted.
- FILL state:
  - buf_free=1.
  - C_wr_en=1 writes C_wr_data to C_wr_addr at the edge.
  - Addresses ≥ M*N are ignored.
  - On results_done=1 → PREFETCH; buf_free falls the next cycle.
  - A write and results_done in the same cycle: the write is performed and is included in the stream.
- PREFETCH state (1 cycle):
  - Presents read address 0 → STREAM.
  - The first AXIS_TVALID=1, carrying C[0], appears exactly 2 cycles after the edge that sampled results_done.
- STREAM state:
  - AXIS_TVALID=1 continuously until the last handshake.
  - A handshake is AXIS_TVALID & AXIS_TREADY at an edge.
  - After a handshake on element i, the next cycle presents element i+1.
  - Sustained throughput is 1 beat/cycle with TREADY held high. No bubbles are allowed; the implementation must prefetch/skid so the RAM latency is hidden.
  - While TREADY=0, TDATA and TLAST hold stable and TVALID stays 1. TVALID never drops before the handshake.
  - AXIS_TLAST=1 only when the element on the bus is index M*N-1.
  - On the handshake of the TLAST beat:
    - next cycle AXIS_TVALID=0, AXIS_TLAST=0;
    - stream_done=1 for exactly that one cycle;
    - buf_free=1;
    - state → FILL.
- Ignored inputs:
  - C_wr_en while buf_free=0: no RAM write.
  - results_done outside FILL.
- Arithmetic: the element counter saturates logic at M*N-1, with no wrap past it. The RAM read address is the counter, width C_ADDR_BITS.
- Frames: back-to-back frames are allowed. A new results_done is accepted in the first FILL cycle after stream_done.

Test Plan:
1. Write C[i]=3*i-100 for i=0..62, results_done, TREADY=1 constant → 63 consecutive beats, TDATA=-100,-97,…,86; first TVALID 2 cycles after results_done; TLAST only on beat 62; stream_done pulses once; buf_free=1 after it.
2. Same data, TREADY random 50% duty → identical ordered sequence; TDATA/TLAST stable during every stall; TVALID never drops mid-frame.
3. TREADY=0 for 10 cycles at frame start → TVALID=1 held with TDATA=-100 for all 10 cycles; then full sequence follows.
4. During STREAM, C_wr_en=1, addr 0, data 32'h7FFF → stream unaffected. Next frame without rewrite still outputs -100 at C[0]; rewriting it in FILL outputs 32767.
5. reset=0 for 1 cycle at beat 20 → next cycle TVALID=0, buf_free=1, no TLAST. A fresh full frame then streams all 63 correct beats.
6. Final write (addr 62, data 5) coincident with results_done → beat 62 carries 5 with TLAST=1. A second results_done in the cycle after stream_done starts frame 2 correctly.

Source files
------------

// File: rtl/output_mems_if.sv
// Result-buffer bus bundle: compute-side write port, frame control,
// and the AXI-Stream master channel that drains the buffered C matrix.
interface output_mems_if #(
  parameter int OUTW = 32,
  parameter int M    = 7,
  parameter int N    = 9
);
  localparam int C_ADDR_BITS = (M * N > 1) ? $clog2(M * N) : 1;

  logic signed [OUTW-1:0]  C_wr_data;
  logic [C_ADDR_BITS-1:0]  C_wr_addr;
  logic                    C_wr_en;
  logic                    results_done;
  logic                    buf_free;
  logic signed [OUTW-1:0]  AXIS_TDATA;
  logic                    AXIS_TVALID;
  logic                    AXIS_TREADY;
  logic                    AXIS_TLAST;
  logic                    stream_done;

  // Buffer side: accepts writes, drives the stream.
  modport master (
    input  C_wr_data, C_wr_addr, C_wr_en, results_done, AXIS_TREADY,
    output buf_free, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST, stream_done
  );

  // Environment side: compute core plus downstream stream consumer.
  modport slave (
    output C_wr_data, C_wr_addr, C_wr_en, results_done, AXIS_TREADY,
    input  buf_free, AXIS_TDATA, AXIS_TVALID, AXIS_TLAST, stream_done
  );
endinterface

// File: rtl/output_mems.sv
// Result buffer for the M x N matrix C. The compute core fills the RAM by
// address while buf_free is high; results_done starts a row-major
// AXI-Stream transfer of every element with TLAST on the final one.
// The stream output register is loaded straight from the synchronous RAM,
// and the read address already points at the element that follows the one
// on the bus, so a handshake can be followed by new data the very next
// cycle without a bubble.
module output_mems #(
  parameter int OUTW = 32,
  parameter int M    = 7,
  parameter int N    = 9
) (
  input  logic          clk,
  input  logic          reset,
  output_mems_if.master bus
);
  localparam int TOTAL       = M * N;
  localparam int C_ADDR_BITS = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int DEPTH       = 1 << C_ADDR_BITS;
  localparam logic [C_ADDR_BITS-1:0] LAST_IDX = C_ADDR_BITS'(TOTAL - 1);
  localparam logic [C_ADDR_BITS:0]   TOTAL_W  = (C_ADDR_BITS + 1)'(TOTAL);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    PREFETCH = 2'd1,
    STREAM   = 2'd2
  } state_t;

  state_t                  state;
  logic signed [OUTW-1:0]  mem [DEPTH];
  logic [C_ADDR_BITS-1:0]  cnt;
  logic [C_ADDR_BITS-1:0]  rd_addr;
  logic signed [OUTW-1:0]  tdata_p1;
  logic                    vld_p1;
  logic                    tlast_p1;
  logic                    buf_free_q;
  logic                    stream_done_q;
  logic                    hs;
  logic                    wr_ok;
  logic                    rd_en;

  // Element index advance that sticks at the last element instead of wrapping.
  function automatic logic [C_ADDR_BITS-1:0] sat_inc(input logic [C_ADDR_BITS-1:0] v);
    return (v == LAST_IDX) ? v : v + C_ADDR_BITS'(1);
  endfunction

  // Addresses at or above M*N fall in the power-of-two padding and are dropped.
  function automatic logic addr_in_range(input logic [C_ADDR_BITS-1:0] a);
    return {1'b0, a} < TOTAL_W;
  endfunction

  assign hs      = vld_p1 & bus.AXIS_TREADY;
  assign wr_ok   = buf_free_q & bus.C_wr_en & addr_in_range(bus.C_wr_addr);
  // The RAM is only read when the bus register must take a new element:
  // once to prime it, then on every handshake except the last.
  assign rd_en   = (state == PREFETCH) | ((state == STREAM) & hs & ~tlast_p1);
  assign rd_addr = (state == PREFETCH) ? '0 : sat_inc(cnt);

  // Compute-side write port; closed whenever a frame is being drained.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[bus.C_wr_addr] <= bus.C_wr_data;
    end
  end

  // ---- stage p1: RAM read straight into the stream data register ----
  // Read port and stream data register; holds during stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tdata_p1 <= '0;
    end else if (rd_en) begin
      tdata_p1 <= mem[rd_addr];
    end
  end

  // Frame FSM with registered stream control, buf_free and stream_done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= FILL;
      cnt           <= '0;
      vld_p1        <= 1'b0;
      tlast_p1      <= 1'b0;
      buf_free_q    <= 1'b1;
      stream_done_q <= 1'b0;
    end else begin
      stream_done_q <= 1'b0;
      case (state)
        FILL: begin
          cnt <= '0;
          if (bus.results_done) begin
            state      <= PREFETCH;
            buf_free_q <= 1'b0;
          end
        end
        PREFETCH: begin
          state    <= STREAM;
          cnt      <= '0;
          vld_p1   <= 1'b1;
          tlast_p1 <= (rd_addr == LAST_IDX);
        end
        STREAM: begin
          if (hs) begin
            if (tlast_p1) begin
              state         <= FILL;
              cnt           <= '0;
              vld_p1        <= 1'b0;
              tlast_p1      <= 1'b0;
              buf_free_q    <= 1'b1;
              stream_done_q <= 1'b1;
            end else begin
              cnt      <= rd_addr;
              tlast_p1 <= (rd_addr == LAST_IDX);
            end
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

  assign bus.AXIS_TDATA  = tdata_p1;
  assign bus.AXIS_TVALID = vld_p1;
  assign bus.AXIS_TLAST  = tlast_p1;
  assign bus.buf_free    = buf_free_q;
  assign bus.stream_done = stream_done_q;

endmodule

// File: tb/tb_output_mems.sv
// Bench for output_mems: table of stream scenarios plus hand-written
// sequences for mid-stream reset and back-to-back frames.
module tb_output_mems;
  localparam int OUTW  = 32;
  localparam int M     = 7;
  localparam int N     = 9;
  localparam int TOTAL = M * N;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  output_mems_if #(.OUTW(OUTW), .M(M), .N(N)) bus ();

  output_mems #(.OUTW(OUTW), .M(M), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [OUTW-1:0] model    [TOTAL];
  logic signed [OUTW-1:0] got      [TOTAL];
  logic                   got_last [TOTAL];
  int                     got_n;

  typedef struct {
    string                  name;
    int                     mode;       // 0 always ready, 1 random, 2 initial stall
    int                     stall_n;
    bit                     poke_wr;    // write C[0] while streaming
    bit                     poke_rd;    // stray results_done while streaming
    int                     exp_cycles; // 0 = not checked
    logic signed [OUTW-1:0] exp_first;
  } scen_t;

  typedef struct {
    int                     beat;
    logic signed [OUTW-1:0] data;
    bit                     last;
  } probe_t;

  scen_t  scen  [5];
  probe_t probe [7];

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic write_frame(input int n);
    for (int i = 0; i < n; i++) begin
      bus.C_wr_en   = 1'b1;
      bus.C_wr_addr = 6'(i);
      bus.C_wr_data = model[i];
      @(negedge clk);
    end
    bus.C_wr_en = 1'b0;
  endtask

  task automatic pulse_done(input bit with_final);
    chk("fill.buf_free", bus.buf_free, 1);
    bus.results_done = 1'b1;
    if (with_final) begin
      bus.C_wr_en   = 1'b1;
      bus.C_wr_addr = 6'(TOTAL - 1);
      bus.C_wr_data = 32'sd5;
    end
    @(negedge clk);
    bus.results_done = 1'b0;
    bus.C_wr_en      = 1'b0;
    chk("prefetch.tvalid", bus.AXIS_TVALID, 0);
    chk("prefetch.buf_free", bus.buf_free, 0);
  endtask

  task automatic run_stream(input string name, input int mode, input int stall_n,
                            input bit poke_wr, input bit poke_rd, input bit chain,
                            input int exp_cycles);
    int cyc = 0;
    int beats = 0;
    int drop_bad = 0, stall_bad = 0, last_bad = 0;
    int done_bad = 0, free_bad = 0, hold_bad = 0;
    bit stalled = 1'b0;
    bit r;
    logic signed [OUTW-1:0] pdata = '0;
    logic plast = 1'b0;
    while (beats < TOTAL && cyc < 4 * TOTAL + 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk($sformatf("%s.first_valid", name), bus.AXIS_TVALID, 1);
      else if (bus.AXIS_TVALID !== 1'b1) drop_bad++;
      if (stalled && (bus.AXIS_TDATA !== pdata || bus.AXIS_TLAST !== plast)) stall_bad++;
      if (bus.AXIS_TVALID && (bus.AXIS_TLAST !== (beats == TOTAL - 1))) last_bad++;
      if (bus.stream_done !== 1'b0) done_bad++;
      if (bus.buf_free !== 1'b0) free_bad++;
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc > stall_n);
      endcase
      if (mode == 2 && cyc <= stall_n && bus.AXIS_TDATA !== model[0]) hold_bad++;
      bus.C_wr_en      = poke_wr && beats >= 5 && beats < 8;
      bus.C_wr_addr    = '0;
      bus.C_wr_data    = 32'sh7FFF;
      bus.results_done = poke_rd && beats == 30;
      bus.AXIS_TREADY  = r;
      if (bus.AXIS_TVALID && r) begin
        got[beats]      = bus.AXIS_TDATA;
        got_last[beats] = bus.AXIS_TLAST;
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = bus.AXIS_TVALID;
        pdata   = bus.AXIS_TDATA;
        plast   = bus.AXIS_TLAST;
      end
    end
    bus.C_wr_en      = 1'b0;
    bus.results_done = 1'b0;
    got_n = beats;
    chk($sformatf("%s.beats", name), beats, TOTAL);
    if (exp_cycles > 0) chk($sformatf("%s.cycles", name), cyc, exp_cycles);
    chk($sformatf("%s.tvalid_drops", name), drop_bad, 0);
    chk($sformatf("%s.stall_unstable", name), stall_bad, 0);
    chk($sformatf("%s.tlast_misplaced", name), last_bad, 0);
    chk($sformatf("%s.early_done", name), done_bad, 0);
    chk($sformatf("%s.buf_free_in_stream", name), free_bad, 0);
    chk($sformatf("%s.stall_data", name), hold_bad, 0);
    for (int i = 0; i < got_n; i++)
      chk($sformatf("%s.beat%0d", name, i), got[i], model[i]);
    @(negedge clk);
    bus.AXIS_TREADY = 1'b0;
    chk($sformatf("%s.end_tvalid", name), bus.AXIS_TVALID, 0);
    chk($sformatf("%s.end_tlast", name), bus.AXIS_TLAST, 0);
    chk($sformatf("%s.end_stream_done", name), bus.stream_done, 1);
    chk($sformatf("%s.end_buf_free", name), bus.buf_free, 1);
    if (chain) begin
      bus.results_done = 1'b1;
      @(negedge clk);
      bus.results_done = 1'b0;
      chk($sformatf("%s.chain_done_low", name), bus.stream_done, 0);
      chk($sformatf("%s.chain_prefetch", name), bus.AXIS_TVALID, 0);
      chk($sformatf("%s.chain_busy", name), bus.buf_free, 0);
    end else begin
      @(negedge clk);
      chk($sformatf("%s.done_once", name), bus.stream_done, 0);
      chk($sformatf("%s.idle_tvalid", name), bus.AXIS_TVALID, 0);
      chk($sformatf("%s.idle_buf_free", name), bus.buf_free, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit found;
    int bad;

    bus.C_wr_en      = 1'b0;
    bus.C_wr_addr    = '0;
    bus.C_wr_data    = '0;
    bus.results_done = 1'b0;
    bus.AXIS_TREADY  = 1'b0;

    scen[0] = '{name: "full_rate",       mode: 0, stall_n: 0,  poke_wr: 0, poke_rd: 0, exp_cycles: 63, exp_first: -32'sd100};
    scen[1] = '{name: "random_ready",    mode: 1, stall_n: 0,  poke_wr: 0, poke_rd: 1, exp_cycles: 0,  exp_first: -32'sd100};
    scen[2] = '{name: "start_stall",     mode: 2, stall_n: 10, poke_wr: 0, poke_rd: 0, exp_cycles: 73, exp_first: -32'sd100};
    scen[3] = '{name: "write_in_stream", mode: 0, stall_n: 0,  poke_wr: 1, poke_rd: 0, exp_cycles: 63, exp_first: -32'sd100};
    scen[4] = '{name: "after_poke",      mode: 0, stall_n: 0,  poke_wr: 0, poke_rd: 0, exp_cycles: 63, exp_first: -32'sd100};

    probe[0] = '{beat: 0,  data: -32'sd100, last: 0};
    probe[1] = '{beat: 1,  data: -32'sd97,  last: 0};
    probe[2] = '{beat: 20, data: -32'sd40,  last: 0};
    probe[3] = '{beat: 33, data: -32'sd1,   last: 0};
    probe[4] = '{beat: 34, data: 32'sd2,    last: 0};
    probe[5] = '{beat: 61, data: 32'sd83,   last: 0};
    probe[6] = '{beat: 62, data: 32'sd86,   last: 1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.tvalid", bus.AXIS_TVALID, 0);
    chk("reset.tlast", bus.AXIS_TLAST, 0);
    chk("reset.tdata", bus.AXIS_TDATA, 0);
    chk("reset.buf_free", bus.buf_free, 1);
    chk("reset.stream_done", bus.stream_done, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < TOTAL; i++) model[i] = OUTW'(3 * i - 100);
    write_frame(TOTAL);

    for (int s = 0; s < 5; s++) begin
      pulse_done(1'b0);
      run_stream(scen[s].name, scen[s].mode, scen[s].stall_n, scen[s].poke_wr,
                 scen[s].poke_rd, 1'b0, scen[s].exp_cycles);
      chk($sformatf("%s.first", scen[s].name), got[0], scen[s].exp_first);
      if (s == 0) begin
        for (int p = 0; p < 7; p++) begin
          chk($sformatf("probe%0d.data", probe[p].beat), got[probe[p].beat], probe[p].data);
          chk($sformatf("probe%0d.last", probe[p].beat), got_last[probe[p].beat], probe[p].last);
        end
      end
    end

    // Rewrite C[0] during FILL: the new value must stream
    bus.C_wr_en   = 1'b1;
    bus.C_wr_addr = '0;
    bus.C_wr_data = 32'sh7FFF;
    @(negedge clk);
    bus.C_wr_en = 1'b0;
    model[0] = 32'sd32767;
    pulse_done(1'b0);
    run_stream("rewrite", 0, 0, 1'b0, 1'b0, 1'b0, 63);
    chk("rewrite.first", got[0], 32'sd32767);

    // Reset while beat 20 is on the bus
    pulse_done(1'b0);
    bus.AXIS_TREADY = 1'b1;
    k = 0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.AXIS_TVALID) begin
        if (k == 20) begin
          found = 1'b1;
          break;
        end
        k++;
      end
    end
    chk("abort.reached_beat20", found, 1);
    chk("abort.beat20_data", bus.AXIS_TDATA, model[20]);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus.AXIS_TREADY = 1'b0;
    chk("abort.tvalid", bus.AXIS_TVALID, 0);
    chk("abort.tlast", bus.AXIS_TLAST, 0);
    chk("abort.tdata", bus.AXIS_TDATA, 0);
    chk("abort.buf_free", bus.buf_free, 1);
    chk("abort.stream_done", bus.stream_done, 0);
    bad = 0;
    bus.AXIS_TREADY = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.AXIS_TVALID !== 1'b0 || bus.AXIS_TLAST !== 1'b0 || bus.stream_done !== 1'b0) bad++;
    end
    bus.AXIS_TREADY = 1'b0;
    chk("abort.quiet", bad, 0);
    pulse_done(1'b0);
    run_stream("post_reset", 0, 0, 1'b0, 1'b0, 1'b0, 63);

    // Final write coincident with results_done, then a chained frame
    for (int i = 0; i < TOTAL - 1; i++) model[i] = OUTW'(3 * i - 100);
    model[TOTAL - 1] = 32'sd5;
    write_frame(TOTAL - 1);
    pulse_done(1'b1);
    run_stream("final_write", 0, 0, 1'b0, 1'b0, 1'b1, 63);
    chk("final_write.beat62", got[TOTAL - 1], 32'sd5);
    chk("final_write.tlast62", got_last[TOTAL - 1], 1);
    run_stream("chained", 0, 0, 1'b0, 1'b0, 1'b0, 63);
    chk("chained.beat62", got[TOTAL - 1], 32'sd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
